// File: rtl/contador_bcd_ctrl.sv
// -----------------------------------------------------------------------------
// contador_bcd_ctrl
//   Run controller for a two-digit BCD counter (00..99) that feeds the
//   7-segment decoders. Pushbutton levels become one-shot commands
//   (LOAD / STOP / START). The digits step up or down once every TICK_DIV
//   clock cycles while the controller is in RUN.
//
// Parameters
//   TICK_DIV     clk cycles per count step (>=1, 1 = one step per cycle)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active high
//   btn_start    in   start/resume request, level, asynchronous to clk
//   btn_stop     in   pause/clear request, level, asynchronous to clk
//   btn_load     in   load preset request, level, asynchronous to clk
//   dir          in   0 = count up, 1 = count down (sampled at each step)
//   wrap_en      in   1 = wrap at the limit, 0 = stop at the limit (DONE)
//   preset_tens  in   preset tens digit, values above 9 clamp to 9
//   preset_ones  in   preset ones digit, values above 9 clamp to 9
//   bcd_tens     out  current tens digit (0..9), registered
//   bcd_ones     out  current ones digit (0..9), registered
//   running      out  high while in RUN, registered
//   done         out  high while in DONE, registered
//   at_limit     out  combinational: 99 when counting up, 00 when down
//   wrap_pulse   out  one-cycle pulse after the step that wrapped, registered
// -----------------------------------------------------------------------------

// Run-time checks on the outputs of the counter controller.
module contador_bcd_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] bcd_tens,
  input logic [3:0] bcd_ones,
  input logic       running,
  input logic       done,
  input logic       wrap_pulse
);

  // Both digits must always hold a decimal value.
  a_digits_decimal: assert property (@(posedge clk) disable iff (rst)
    (bcd_tens <= 4'd9) && (bcd_ones <= 4'd9));

  // RUN and DONE are distinct states.
  a_state_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(running && done));

  // A wrap can only happen on a step taken while running.
  a_wrap_in_run: assert property (@(posedge clk) disable iff (rst)
    wrap_pulse |-> running);

  // A wrap always lands on one of the two limits.
  a_wrap_lands_on_limit: assert property (@(posedge clk) disable iff (rst)
    wrap_pulse |-> (((bcd_tens == 4'd0) && (bcd_ones == 4'd0)) ||
                    ((bcd_tens == 4'd9) && (bcd_ones == 4'd9))));

endmodule

module contador_bcd_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_load,
  input  logic       dir,
  input  logic       wrap_en,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       done,
  output logic       at_limit,
  output logic       wrap_pulse
);

  // Prescaler width; at least one bit so TICK_DIV = 1 still builds.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Out-of-range preset digits saturate at 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      return 4'd9;
    end else begin
      return d;
    end
  endfunction

  // BCD increment of a two-digit value below 99: {tens, ones}.
  function automatic logic [7:0] bcd_up(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd9) begin
      return {t + 4'd1, 4'd0};
    end else begin
      return {t, o + 4'd1};
    end
  endfunction

  // BCD decrement of a two-digit value above 00: {tens, ones}.
  function automatic logic [7:0] bcd_down(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd0) begin
      return {t - 4'd1, 4'd9};
    end else begin
      return {t, o - 4'd1};
    end
  endfunction

  // Button bits are packed as {load, stop, start}.
  logic [2:0]    btn_s;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    prev_r;
  logic [2:0]    cmd_s;
  logic          cmd_load_s;
  logic          cmd_stop_s;
  logic          cmd_start_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    tens_r;
  logic [3:0]    ones_r;
  logic [3:0]    tens_next_s;
  logic [3:0]    ones_next_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_next_s;
  logic          wrap_r;
  logic          wrap_next_s;
  logic          running_r;
  logic          done_r;
  logic          limit_s;
  logic [7:0]    up_s;
  logic [7:0]    down_s;

  assign btn_s = {btn_load, btn_stop, btn_start};

  // Two-stage synchronizer followed by a history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      prev_r  <= 3'b000;
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // One-cycle command on each synchronized rising edge; only the
  // highest-priority command (load > stop > start) is passed on.
  assign cmd_s       = sync2_r & ~prev_r;
  assign cmd_load_s  = cmd_s[2];
  assign cmd_stop_s  = cmd_s[1] & ~cmd_s[2];
  assign cmd_start_s = cmd_s[0] & ~cmd_s[1] & ~cmd_s[2];

  // Limit depends on the direction currently requested.
  assign limit_s = dir ? ((tens_r == 4'd0) && (ones_r == 4'd0))
                       : ((tens_r == 4'd9) && (ones_r == 4'd9));
  assign up_s    = bcd_up(tens_r, ones_r);
  assign down_s  = bcd_down(tens_r, ones_r);

  // Next-state, digit and prescaler logic. A command that acts on this
  // cycle pre-empts any step that would have been taken.
  always_comb begin
    state_next_s = state_r;
    tens_next_s  = tens_r;
    ones_next_s  = ones_r;
    presc_next_s = {PW{1'b0}};
    wrap_next_s  = 1'b0;
    if (cmd_load_s) begin
      state_next_s = ST_IDLE;
      tens_next_s  = clamp_digit(preset_tens);
      ones_next_s  = clamp_digit(preset_ones);
    end else if (cmd_stop_s) begin
      case (state_r)
        ST_RUN: begin
          state_next_s = ST_PAUSED;
        end
        ST_PAUSED: begin
          state_next_s = ST_IDLE;
          tens_next_s  = 4'd0;
          ones_next_s  = 4'd0;
        end
        ST_DONE: begin
          state_next_s = ST_IDLE;
        end
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
          tens_next_s  = 4'd0;
          ones_next_s  = 4'd0;
        end
      endcase
    end else if (cmd_start_s && ((state_r == ST_IDLE) || (state_r == ST_PAUSED))) begin
      state_next_s = ST_RUN;
    end else if ((state_r == ST_RUN) && (presc_r == PRESC_MAX)) begin
      // Count step; the prescaler restarts from zero.
      if (limit_s) begin
        if (wrap_en) begin
          tens_next_s = dir ? 4'd9 : 4'd0;
          ones_next_s = dir ? 4'd9 : 4'd0;
          wrap_next_s = 1'b1;
        end else begin
          state_next_s = ST_DONE;
        end
      end else if (dir) begin
        tens_next_s = down_s[7:4];
        ones_next_s = down_s[3:0];
      end else begin
        tens_next_s = up_s[7:4];
        ones_next_s = up_s[3:0];
      end
    end else if (state_r == ST_RUN) begin
      presc_next_s = presc_r + PW'(1);
    end else begin
      presc_next_s = {PW{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Digit, prescaler and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
      presc_r   <= {PW{1'b0}};
      wrap_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      tens_r    <= tens_next_s;
      ones_r    <= ones_next_s;
      presc_r   <= presc_next_s;
      wrap_r    <= wrap_next_s;
      running_r <= (state_next_s == ST_RUN);
      done_r    <= (state_next_s == ST_DONE);
    end
  end

  assign bcd_tens   = tens_r;
  assign bcd_ones   = ones_r;
  assign running    = running_r;
  assign done       = done_r;
  assign wrap_pulse = wrap_r;
  assign at_limit   = limit_s;

  contador_bcd_ctrl_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .bcd_tens   (tens_r),
    .bcd_ones   (ones_r),
    .running    (running_r),
    .done       (done_r),
    .wrap_pulse (wrap_r)
  );

endmodule

// File: tb/tb_contador_bcd_ctrl.sv
// Self-checking bench for contador_bcd_ctrl. Two instances share all inputs:
// dut_f steps every cycle (TICK_DIV = 1), dut_s every fourth (TICK_DIV = 4).
// A reference model tracks each count as an integer 0..99.
module tb_contador_bcd_ctrl;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSED = 2;
  localparam int S_DONE   = 3;

  logic       clk;
  logic       rst;
  logic       btn_start, btn_stop, btn_load, dir, wrap_en;
  logic [3:0] preset_tens, preset_ones;
  logic [3:0] f_tens, f_ones, s_tens, s_ones;
  logic       f_running, f_done, f_at_limit, f_wrap;
  logic       s_running, s_done, s_at_limit, s_wrap;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state, index 0 = dut_f, 1 = dut_s
  int m_st  [2];
  int m_val [2];
  int m_p   [2];
  int m_wrap[2];
  // sampled button history, [0] = most recent edge
  int h_ld[3];
  int h_sp[3];
  int h_st[3];

  int hold;
  int sel;
  int wrap_cnt;
  int saved;

  contador_bcd_ctrl #(.TICK_DIV(1)) dut_f (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_load(btn_load), .dir(dir), .wrap_en(wrap_en),
    .preset_tens(preset_tens), .preset_ones(preset_ones),
    .bcd_tens(f_tens), .bcd_ones(f_ones), .running(f_running),
    .done(f_done), .at_limit(f_at_limit), .wrap_pulse(f_wrap)
  );

  contador_bcd_ctrl #(.TICK_DIV(4)) dut_s (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_load(btn_load), .dir(dir), .wrap_en(wrap_en),
    .preset_tens(preset_tens), .preset_ones(preset_ones),
    .bcd_tens(s_tens), .bcd_ones(s_ones), .running(s_running),
    .done(s_done), .at_limit(s_at_limit), .wrap_pulse(s_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int clampd(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic int f_val();
    return int'(f_tens) * 10 + int'(f_ones);
  endfunction

  function automatic int s_val();
    return int'(s_tens) * 10 + int'(s_ones);
  endfunction

  task automatic chk(input string name, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_IDLE; m_val[k] = 0; m_p[k] = 0; m_wrap[k] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      h_ld[i] = 0; h_sp[i] = 0; h_st[i] = 0;
    end
  endtask

  // One rising clock edge of the reference model, using input levels now.
  task automatic model_edge();
    int c_ld, c_sp, c_st, td, tgt;
    if (rst) begin
      model_reset();
      return;
    end
    // a level first seen at edge k acts at edge k+2 if it was low at edge k-1
    c_ld = (h_ld[1] == 1 && h_ld[2] == 0) ? 1 : 0;
    c_sp = (h_sp[1] == 1 && h_sp[2] == 0 && c_ld == 0) ? 1 : 0;
    c_st = (h_st[1] == 1 && h_st[2] == 0 && c_ld == 0 && c_sp == 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      td = (k == 0) ? 1 : 4;
      m_wrap[k] = 0;
      if (c_ld == 1) begin
        m_val[k] = clampd(int'(preset_tens)) * 10 + clampd(int'(preset_ones));
        m_st[k]  = S_IDLE;
      end else if (c_sp == 1) begin
        if (m_st[k] == S_RUN) m_st[k] = S_PAUSED;
        else if (m_st[k] == S_PAUSED) begin m_st[k] = S_IDLE; m_val[k] = 0; end
        else if (m_st[k] == S_DONE) m_st[k] = S_IDLE;
      end else if (c_st == 1 && (m_st[k] == S_IDLE || m_st[k] == S_PAUSED)) begin
        m_st[k] = S_RUN;
        m_p[k]  = 0;
      end else if (m_st[k] == S_RUN) begin
        m_p[k]++;
        if (m_p[k] == td) begin
          m_p[k] = 0;
          tgt = dir ? m_val[k] - 1 : m_val[k] + 1;
          if (tgt < 0 || tgt > 99) begin
            if (wrap_en) begin m_val[k] = (tgt + 100) % 100; m_wrap[k] = 1; end
            else m_st[k] = S_DONE;
          end else begin
            m_val[k] = tgt;
          end
        end
      end
    end
    h_ld[2] = h_ld[1]; h_ld[1] = h_ld[0]; h_ld[0] = int'(btn_load);
    h_sp[2] = h_sp[1]; h_sp[1] = h_sp[0]; h_sp[0] = int'(btn_stop);
    h_st[2] = h_st[1]; h_st[1] = h_st[0]; h_st[0] = int'(btn_start);
  endtask

  task automatic check_all(input string tag);
    int lim_f, lim_s;
    lim_f = dir ? ((m_val[0] == 0) ? 1 : 0) : ((m_val[0] == 99) ? 1 : 0);
    lim_s = dir ? ((m_val[1] == 0) ? 1 : 0) : ((m_val[1] == 99) ? 1 : 0);
    chk({tag, ".f_tens"},  int'(f_tens),     m_val[0] / 10);
    chk({tag, ".f_ones"},  int'(f_ones),     m_val[0] % 10);
    chk({tag, ".f_run"},   int'(f_running),  (m_st[0] == S_RUN)  ? 1 : 0);
    chk({tag, ".f_done"},  int'(f_done),     (m_st[0] == S_DONE) ? 1 : 0);
    chk({tag, ".f_limit"}, int'(f_at_limit), lim_f);
    chk({tag, ".f_wrap"},  int'(f_wrap),     m_wrap[0]);
    chk({tag, ".s_tens"},  int'(s_tens),     m_val[1] / 10);
    chk({tag, ".s_ones"},  int'(s_ones),     m_val[1] % 10);
    chk({tag, ".s_run"},   int'(s_running),  (m_st[1] == S_RUN)  ? 1 : 0);
    chk({tag, ".s_done"},  int'(s_done),     (m_st[1] == S_DONE) ? 1 : 0);
    chk({tag, ".s_limit"}, int'(s_at_limit), lim_s);
    chk({tag, ".s_wrap"},  int'(s_wrap),     m_wrap[1]);
  endtask

  // one clock: model follows the rising edge, outputs checked on the falling edge
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_load = 1'b0;
    dir = 1'b0; wrap_en = 1'b1; preset_tens = 4'd0; preset_ones = 4'd0;
    hold = 0; sel = 0; wrap_cnt = 0; saved = 0;
    model_reset();

    // reset state, before any clock edge
    #1 rst = 1'b1;
    #1 check_all("reset");
    cycle("reset");
    cycle("reset");
    rst = 1'b0;

    // T1: count up from 00 with wrap enabled, 100 fast steps
    btn_start = 1'b1;
    cycle("t1.start");
    cycle("t1.start");
    btn_start = 1'b0;
    cycle("t1.start");
    chk("t1.running", int'(f_running), 1);
    for (int i = 0; i < 100; i++) begin
      cycle("t1.count");
      if (f_wrap) wrap_cnt++;
      if (i == 98) chk("t1.at99", f_val(), 99);
    end
    chk("t1.wraps", wrap_cnt, 1);
    chk("t1.final", f_val(), 0);

    // T2: load clamped preset 0xC/0x3 -> 93, count down to DONE
    dir = 1'b1; wrap_en = 1'b0; preset_tens = 4'hC; preset_ones = 4'h3;
    btn_load = 1'b1;
    cycle("t2.load");
    btn_load = 1'b0;
    cycle("t2.load");
    cycle("t2.load");
    chk("t2.loaded_s", s_val(), 93);
    chk("t2.loaded_f", f_val(), 93);
    btn_start = 1'b1;
    cycle("t2.start");
    btn_start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cycle("t2.down");
      if (s_done) break;
    end
    chk("t2.done", int'(s_done), 1);
    chk("t2.digits", s_val(), 0);
    cycle("t2.hold");
    chk("t2.still00", s_val(), 0);

    // T3: stop from DONE, then start held for 20 cycles, then stop twice
    btn_stop = 1'b1;
    cycle("t3.stop0");
    btn_stop = 1'b0;
    cycle("t3.stop0");
    cycle("t3.stop0");
    dir = 1'b0; wrap_en = 1'b1;
    btn_start = 1'b1;
    cycle("t3.e1");
    chk("t3.run_e1", int'(s_running), 0);
    cycle("t3.e2");
    chk("t3.run_e2", int'(s_running), 0);
    cycle("t3.e3");
    chk("t3.run_e3", int'(s_running), 1);
    for (int i = 0; i < 17; i++) cycle("t3.held");
    btn_start = 1'b0;
    btn_stop = 1'b1;
    cycle("t3.stop1");
    btn_stop = 1'b0;
    cycle("t3.stop1");
    cycle("t3.stop1");
    saved = f_val();
    for (int i = 0; i < 5; i++) cycle("t3.paused");
    chk("t3.held_digits", f_val(), saved);
    chk("t3.paused_run", int'(f_running), 0);
    btn_stop = 1'b1;
    cycle("t3.stop2");
    btn_stop = 1'b0;
    cycle("t3.stop2");
    cycle("t3.stop2");
    chk("t3.cleared", f_val(), 0);

    // T4: load + stop + start on the same cycle while running
    btn_start = 1'b1;
    cycle("t4.start");
    btn_start = 1'b0;
    for (int i = 0; i < 7; i++) cycle("t4.run");
    preset_tens = 4'd4; preset_ones = 4'd7;
    btn_load = 1'b1; btn_stop = 1'b1; btn_start = 1'b1;
    cycle("t4.all");
    btn_load = 1'b0; btn_stop = 1'b0; btn_start = 1'b0;
    cycle("t4.all");
    cycle("t4.all");
    chk("t4.run", int'(s_running), 0);
    chk("t4.val", s_val(), 47);

    // T5: up to 19, then 20, then flip direction -> 19, 18
    preset_tens = 4'd1; preset_ones = 4'd5;
    btn_load = 1'b1;
    cycle("t5.load");
    btn_load = 1'b0;
    cycle("t5.load");
    cycle("t5.load");
    btn_start = 1'b1;
    cycle("t5.start");
    btn_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle("t5.up");
      if (f_val() == 19) break;
    end
    chk("t5.reach19", f_val(), 19);
    cycle("t5.step");
    chk("t5.v20", f_val(), 20);
    dir = 1'b1;
    cycle("t5.step");
    chk("t5.v19", f_val(), 19);
    cycle("t5.step");
    chk("t5.v18", f_val(), 18);

    // T6: asynchronous reset mid-run at 57
    dir = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle("t6.up");
      if (f_val() == 57) break;
    end
    chk("t6.reach57", f_val(), 57);
    #1 rst = 1'b1;
    #1 model_reset();
    check_all("t6.rst");
    chk("t6.run", int'(f_running), 0);
    chk("t6.val", f_val(), 0);
    #1 rst = 1'b0;

    // randomized commands, direction, wrap mode and presets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 31) == 0) wrap_en = ~wrap_en;
      if ($urandom_range(0, 7) == 0) begin
        preset_tens = 4'($urandom_range(0, 15));
        preset_ones = 4'($urandom_range(0, 15));
      end
      if (hold > 0) begin
        hold--;
      end else begin
        btn_start = 1'b0; btn_stop = 1'b0; btn_load = 1'b0;
        if ($urandom_range(0, 11) == 0) begin
          sel = int'($urandom_range(0, 3));
          case (sel)
            0, 1:    btn_start = 1'b1;
            2:       btn_stop  = 1'b1;
            default: btn_load  = 1'b1;
          endcase
          hold = int'($urandom_range(0, 3));
        end
      end
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
